// File: rtl/osc_period_divider.sv
// osc_period_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Operands are taken through a start/busy/done handshake.
// A target count is turned back into a ratio for the oscillator tuning-word path.
// Optional feature: define OSC_DIV_ROUND_EN to add a round-to-nearest step on the quotient.
// The rounding step adds one clock of latency.
module osc_period_divider #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   // S_ROUND is reachable only when the rounding step is compiled in.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_ROUND  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   r;          // partial remainder
   logic [WIDTH-1:0]   q;          // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0]   dvsr;       // divisor latched at accept
   logic [CNT_W-1:0]   n;          // remaining bit steps minus one
   logic               dz;         // divide-by-zero seen at accept

   logic [WIDTH-1:0]   shifted;
   logic [WIDTH:0]     trial;
   logic               round_up;

   // Partial remainder shifted left with the next dividend bit.
   // Before the final step, r is below 2^(WIDTH-1), so r's top bit can be dropped safely.
   assign shifted  = {r[WIDTH-2:0], q[WIDTH-1]};
   assign trial    = {1'b0, shifted} - {1'b0, dvsr};
   assign round_up = ({r, 1'b0} >= {1'b0, dvsr});

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so that all registers
      // update together from the values they held before the edge.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: assign a default first so that no path through the case leaves
      // state_next unassigned, which would infer a latch.
      state_next = state;
      unique case (state)
         S_IDLE:   if (start) state_next = (divisor == '0) ? S_FINISH : S_RUN;
`ifdef OSC_DIV_ROUND_EN
         S_RUN:    if (n == '0) state_next = S_ROUND;
`else
         S_RUN:    if (n == '0) state_next = S_FINISH;
`endif
         S_ROUND:  state_next = S_FINISH;
         S_FINISH: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Datapath: operand latch, one trial subtraction per RUN cycle, optional rounding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r    <= '0;
         q    <= '0;
         dvsr <= '0;
         n    <= '0;
         dz   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  dvsr <= divisor;
                  if (divisor == '0) begin
                     // Results are staged here and published by FINISH.
                     q  <= '1;
                     r  <= dividend;
                     dz <= 1'b1;
                  end else begin
                     q  <= dividend;
                     r  <= '0;
                     n  <= CNT_W'(WIDTH - 1);
                     dz <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (!trial[WIDTH]) begin
                  r <= trial[WIDTH-1:0];
                  q <= {q[WIDTH-2:0], 1'b1};
               end else begin
                  r <= shifted;
                  q <= {q[WIDTH-2:0], 1'b0};
               end
               if (n != '0) n <= n - CNT_W'(1);
            end
            S_ROUND: begin
               // Round half up on the quotient, saturating at all ones.
               // The remainder stays unrounded.
               if (round_up && (q != '1)) q <= q + WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   // Registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            // busy stays high through the done cycle.
            // busy falls on the edge that ends it, unless a new start is accepted there.
            S_IDLE: busy <= start;
            S_FINISH: begin
               quotient    <= q;
               remainder   <= r;
               div_by_zero <= dz;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/osc_period_divider.md
# osc_period_divider

Sequential 17-bit unsigned restoring divider for the oscillator datapath. It inverts the phase-accumulator relationship: a phase increment is built by repeated addition, and this block converts a target count back into a ratio by repeated trial subtraction. One quotient bit is produced per clock, and operands and results are handled through a start/busy/done handshake. The block sits between the control/register logic and the oscillator tuning-word path, which consumes `quotient` when `done` pulses.

## Interface
- `WIDTH`, default 17: operand and result width. The test plan covers the default only.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a division. Sampled only in IDLE.
- `dividend`  in  WIDTH: numerator, unsigned. Latched on the accepted `start`.
- `divisor`  in  WIDTH: denominator, unsigned. Latched on the accepted `start`.
- `quotient`  out  WIDTH: result. Holds its value until the next completion.
- `remainder`  out  WIDTH: result remainder. Holds its value until the next completion.
- `busy`  out  1: high while an accepted operation is in progress.
- `done`  out  1: one-cycle pulse, high in the cycle in which the results become valid.
- `div_by_zero`  out  1: flag for the last completed operation. Valid from `done` until the next `done`.

## Operation
- Reset value of every output is 0. The reset is asynchronous and takes effect immediately mid-operation; the operation is abandoned and the FSM returns to IDLE.
- FSM states:
  - IDLE: `busy`=0. On `start`=1, latch both operands.
    - If `divisor`=0: go to FINISH with `quotient`=all ones, `remainder`=`dividend`, `div_by_zero`=1.
    - Otherwise: clear the partial remainder `r`, load the shift register `q`=`dividend`, set bit counter `n`=WIDTH-1, go to RUN.
  - RUN: `busy`=1. Each cycle:
    - trial value `t` = {`r`[WIDTH-2:0], `q`[WIDTH-1]} minus `divisor`, computed at WIDTH+1 bits.
    - If `t` is non-negative: `r`=`t`[WIDTH-1:0] and shift 1 into `q`.
    - Otherwise: `r`={`r`[WIDTH-2:0], `q`[WIDTH-1]} and shift 0 into `q`.
    - When `n`=0, go to FINISH (or ROUND when the rounding macro is compiled in). Otherwise decrement `n`.
  - FINISH: `busy`=1. Register `quotient`=`q`, `remainder`=`r`, `div_by_zero`=0 (unless it was set in IDLE), and pulse `done`. Go to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor allowed to corrupt latched operands. Changing `dividend` or `divisor` mid-run has no effect.
- `start` held high across `done` is accepted in the first IDLE cycle after FINISH, so operations can run back to back.
- Results are exact: `dividend` = `quotient`×`divisor` + `remainder`, and `remainder` < `divisor`.

## Timing
- Start is accepted at edge E0.
- Normal case: RUN occupies edges E1..E17. FINISH registers the outputs at E18, so `done` is high from E18 to E19 (latency 18 clocks).
- Divide-by-zero case: FINISH at E1, so `done` is high from E1 to E2.
- `busy` rises at E0 and falls at the edge that ends the `done` cycle. The earliest next accept is at that same edge if `start`=1.
- Outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `OSC_DIV_ROUND_EN`
  - Defined: adds a ROUND state between RUN and FINISH. If 2×`r` ≥ `divisor`, then `quotient`=`q`+1, saturating at all ones; `remainder` reports the unrounded `r`. Normal latency becomes 19 clocks. Divide-by-zero behaviour and its latency are unchanged.
  - Undefined: no ROUND state; the quotient is truncated and latency is 18 clocks.

## Test plan
- `dividend`=100, `divisor`=7, `start` pulse -> `done` 18 clocks later, `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high throughout.
- `dividend`=17'h1FFFF, `divisor`=1 -> `quotient`=17'h1FFFF, `remainder`=0. Then `dividend`=3, `divisor`=17'h1FFFF -> `quotient`=0, `remainder`=3.
- `dividend`=5, `divisor`=0 -> `done` 1 clock after accept, `quotient`=17'h1FFFF, `remainder`=5, `div_by_zero`=1. A following 9/3 clears the flag and gives `quotient`=3, `remainder`=0.
- Start 50/5, then at run cycle 6 change the operands to 99/2 and pulse `start` -> the result is still `quotient`=10, `remainder`=0, and only one `done` pulse occurs.
- Assert `rst_n`=0 at run cycle 8 of 1000/3 -> all outputs 0 immediately. After release, 1000/3 completes with `quotient`=333, `remainder`=1.
- With `OSC_DIV_ROUND_EN`: 100/8 -> `quotient`=13, `remainder`=4, latency 19. 17'h1FFFF/17'h1FFFF -> `quotient`=1, `remainder`=0 (no rounding increment).
